register_file: RTL and testbench

//  Architectural 32x32 GPR file of the single-cycle datapath. Both read ports supply the ALU

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/register_file_read_port.sv | 40 ++++
 rtl/register_file.sv | 99 +++++++++
 tb/tb_register_file.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared datapath types: machine word, register index and the ALU status flag bundle.
// Latency: n/a (types only).
// Backpressure: n/a.
package cpu_types_pkg;

  localparam int WORD_W    = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [REG_IDX_W-1:0] regbits_t;

  // Status register layout, MSB first: sticky overflow, negative, zero.
  typedef struct packed {
    logic ovf;
    logic neg;
    logic zero;
  } rf_flags_t;

endpackage

// File: rtl/register_file_read_port.sv
// One combinational GPR read port: index -> data, index 0 and out-of-range indices read 0.
// Latency: combinational. With RF_BYPASS_EN defined, a same-cycle write to the selected index is forwarded.
// Backpressure: none, always answers.
module rf_read_port
  import cpu_types_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int DW    = 32
) (
  input  regbits_t                  i_rsel,
  input  logic [NREGS-1:0][DW-1:0]  i_regs,
`ifdef RF_BYPASS_EN
  input  logic                      i_wen,
  input  regbits_t                  i_wsel,
  input  logic [DW-1:0]             i_wdat,
`endif
  output logic [DW-1:0]             o_rdat
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic w_valid;

  // Register 0 and indices past the end of the array never return stored data.
  assign w_valid = (i_rsel != '0) && (32'(i_rsel) < NREGS);

  // Select the stored word, optionally overridden by the write port in the same cycle.
  always_comb begin
    o_rdat = '0;
    if (w_valid) begin
      o_rdat = i_regs[i_rsel[IW-1:0]];
`ifdef RF_BYPASS_EN
      if (i_wen && (i_wsel == i_rsel)) begin
        o_rdat = i_wdat;
      end
`endif
    end
  end

endmodule

// File: rtl/register_file.sv
// 32x32 GPR file with two read ports, one write port, ALU status flags and a saturating overflow counter.
// Latency: reads combinational, writes/flags visible the cycle after the edge (RF_BYPASS_EN forwards writes).
// Backpressure: none; every write and flag capture is accepted on the edge it is presented.
module register_file
  import cpu_types_pkg::*;
#(
  parameter int NREGS     = 32,
  parameter int DW        = 32,
  parameter int OVF_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 WEN,
  input  regbits_t             wsel,
  input  logic [DW-1:0]        wdat,
  input  regbits_t             rsel1,
  input  regbits_t             rsel2,
  output logic [DW-1:0]        rdat1,
  output logic [DW-1:0]        rdat2,
  input  logic                 flag_wen,
  input  logic                 zero_in,
  input  logic                 neg_in,
  input  logic                 ovf_in,
  output logic [2:0]           flags,
  input  logic                 ovf_clr,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  logic [NREGS-1:0][DW-1:0] r_regs;
  rf_flags_t                r_flags;
  logic [OVF_CNT_W-1:0]     r_ovf_cnt;

  // Register array: entry 0 is never written so it stays at its reset value of zero.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_regs <= '0;
    end else if (WEN) begin
      for (int i = 1; i < NREGS; i++) begin
        if (wsel == regbits_t'(i)) begin
          r_regs[i] <= wdat;
        end
      end
    end
  end

  // Status flags and overflow counter; a clear beats a simultaneous overflow capture.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_flags   <= '0;
      r_ovf_cnt <= '0;
    end else begin
      if (flag_wen) begin
        r_flags.zero <= zero_in;
        r_flags.neg  <= neg_in;
      end
      if (ovf_clr) begin
        r_flags.ovf <= 1'b0;
        r_ovf_cnt   <= '0;
      end else if (flag_wen && ovf_in) begin
        r_flags.ovf <= 1'b1;
        if (r_ovf_cnt != '1) begin
          r_ovf_cnt <= r_ovf_cnt + 1'b1;
        end
      end
    end
  end

  assign flags     = r_flags;
  assign ovf_count = r_ovf_cnt;

  rf_read_port #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_rd1 (
    .i_rsel (rsel1),
    .i_regs (r_regs),
`ifdef RF_BYPASS_EN
    .i_wen  (WEN),
    .i_wsel (wsel),
    .i_wdat (wdat),
`endif
    .o_rdat (rdat1)
  );

  rf_read_port #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_rd2 (
    .i_rsel (rsel2),
    .i_regs (r_regs),
`ifdef RF_BYPASS_EN
    .i_wen  (WEN),
    .i_wsel (wsel),
    .i_wdat (wdat),
`endif
    .o_rdat (rdat2)
  );

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed cases plus randomized traffic against a behavioural model.
// Latency: model updates on each posedge; outputs compared every negedge.
// Backpressure: n/a.
module tb_register_file;

  localparam int NREGS     = 32;
  localparam int DW        = 32;
  localparam int OVF_CNT_W = 8;
  localparam int CNT_MAX   = (1 << OVF_CNT_W) - 1;

  logic                 CLK = 1'b0;
  logic                 nRST = 1'b1;
  logic                 WEN = 1'b0;
  logic [4:0]           wsel = '0;
  logic [DW-1:0]        wdat = '0;
  logic [4:0]           rsel1 = '0;
  logic [4:0]           rsel2 = '0;
  logic [DW-1:0]        rdat1;
  logic [DW-1:0]        rdat2;
  logic                 flag_wen = 1'b0;
  logic                 zero_in = 1'b0;
  logic                 neg_in = 1'b0;
  logic                 ovf_in = 1'b0;
  logic [2:0]           flags;
  logic                 ovf_clr = 1'b0;
  logic [OVF_CNT_W-1:0] ovf_count;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Behavioural model state
  logic [31:0] m_regs [NREGS];
  bit          m_zero, m_neg, m_ovf;
  int          m_cnt;

  register_file #(
    .NREGS     (NREGS),
    .DW        (DW),
    .OVF_CNT_W (OVF_CNT_W)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .WEN       (WEN),
    .wsel      (wsel),
    .wdat      (wdat),
    .rsel1     (rsel1),
    .rsel2     (rsel2),
    .rdat1     (rdat1),
    .rdat2     (rdat2),
    .flag_wen  (flag_wen),
    .zero_in   (zero_in),
    .neg_in    (neg_in),
    .ovf_in    (ovf_in),
    .flags     (flags),
    .ovf_clr   (ovf_clr),
    .ovf_count (ovf_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] sel);
    if (sel == 0 || int'(sel) >= NREGS) return 32'h0;
`ifdef RF_BYPASS_EN
    if (WEN && wsel != 0 && wsel == sel) return wdat;
`endif
    return m_regs[sel];
  endfunction

  // Model: architectural effect of each clock edge / reset
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      m_zero = 0; m_neg = 0; m_ovf = 0; m_cnt = 0;
    end else begin
      if (WEN && wsel != 0 && int'(wsel) < NREGS) m_regs[wsel] = wdat;
      if (flag_wen) begin
        m_zero = zero_in;
        m_neg  = neg_in;
      end
      if (ovf_clr) begin
        m_ovf = 0;
        m_cnt = 0;
      end else if (flag_wen && ovf_in) begin
        m_ovf = 1;
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end
    end
  end

  // Compare process: every negedge while enabled
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("rdat1", rdat1, exp_rd(rsel1));
      chk("rdat2", rdat2, exp_rd(rsel2));
      chk("flags", {29'b0, flags}, {29'b0, m_ovf, m_neg, m_zero});
      chk("ovf_count", {24'b0, ovf_count}, 32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    foreach (m_regs[i]) m_regs[i] = 32'h0;
    m_zero = 0; m_neg = 0; m_ovf = 0; m_cnt = 0;

    // Initial reset, asserted before any clock edge
    #3 nRST = 1'b0;
    #1;
    chk("rst0_rdat1", rdat1, 32'h0);
    chk("rst0_rdat2", rdat2, 32'h0);
    chk("rst0_flags", {29'b0, flags}, 32'h0);
    chk("rst0_cnt", {24'b0, ovf_count}, 32'h0);
    repeat (2) step();
    nRST = 1'b1;
    cmp_en = 1'b1;

    // Write reg5 and attempt a write to reg0
    step(); WEN = 1; wsel = 5; wdat = 32'hDEADBEEF;
    step(); wsel = 0; wdat = 32'hFFFFFFFF;
    step(); WEN = 0; rsel1 = 5; rsel2 = 0;
    #2;
    chk("t2_rdat1", rdat1, 32'hDEADBEEF);
    chk("t2_rdat2", rdat2, 32'h0);

    // Same-cycle read/write of reg7
    step(); WEN = 1; wsel = 7; wdat = 32'hA5A5A5A5;
    step(); WEN = 1; wsel = 7; wdat = 32'h00001234; rsel1 = 7;
    #2;
`ifdef RF_BYPASS_EN
    chk("t3_same_cycle", rdat1, 32'h00001234);
`else
    chk("t3_same_cycle", rdat1, 32'hA5A5A5A5);
`endif
    step(); WEN = 0;
    #2;
    chk("t3_next_cycle", rdat1, 32'h00001234);

    // 300 overflow captures saturate the counter
    step(); flag_wen = 1; ovf_in = 1; neg_in = 1; zero_in = 0;
    repeat (299) step();
    step(); flag_wen = 0; ovf_in = 0;
    #2;
    chk("t4_cnt_sat", {24'b0, ovf_count}, 32'd255);
    chk("t4_flags", {29'b0, flags}, 32'b110);

    // Clear wins over simultaneous overflow capture
    step(); ovf_clr = 1; ovf_in = 1; flag_wen = 1; zero_in = 1; neg_in = 0;
    step(); ovf_clr = 0; ovf_in = 0; flag_wen = 0; zero_in = 0;
    #2;
    chk("t5_cnt", {24'b0, ovf_count}, 32'd0);
    chk("t5_flags", {29'b0, flags}, 32'b001);

    // Counter counts again after clear; flag_wen=0 holds
    step(); flag_wen = 1; ovf_in = 1; zero_in = 0;
    repeat (2) step();
    step(); flag_wen = 0; ovf_in = 0; zero_in = 1;
    repeat (2) step();
    #2;
    chk("t5b_cnt", {24'b0, ovf_count}, 32'd3);
    chk("t5b_flags", {29'b0, flags}, 32'b100);

    // Reset mid-cycle clears immediately
    step(); rsel1 = 5; rsel2 = 7;
    #2;
    chk("t1_pre_rdat1", rdat1, 32'hDEADBEEF);
    nRST = 1'b0;
    #1;
    chk("t1_rdat1", rdat1, 32'h0);
    chk("t1_rdat2", rdat2, 32'h0);
    chk("t1_flags", {29'b0, flags}, 32'h0);
    chk("t1_cnt", {24'b0, ovf_count}, 32'h0);
    // A write presented on an edge while reset is held must not land
    WEN = 1; wsel = 9; wdat = 32'hCAFEF00D;
    step();
    nRST = 1'b1; WEN = 0; rsel1 = 9;
    #2;
    chk("t1_no_write_in_rst", rdat1, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 10000; n++) begin
      step();
      WEN      = ($urandom_range(0, 3) != 0);
      wsel     = 5'($urandom_range(0, 31));
      wdat     = $urandom;
      rsel1    = ($urandom_range(0, 3) == 0) ? wsel : 5'($urandom_range(0, 31));
      rsel2    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      flag_wen = $urandom_range(0, 1);
      zero_in  = $urandom_range(0, 1);
      neg_in   = $urandom_range(0, 1);
      ovf_in   = ($urandom_range(0, 2) != 0);
      ovf_clr  = ($urandom_range(0, 127) == 0);
    end
    step();
    WEN = 0; flag_wen = 0; ovf_clr = 0;
    step();
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
